// File: rtl/bsk_prd_pkg.sv
// bsk_prd_pkg: shared constants and byte encoding helper for the BSK command board slave
package bsk_prd_pkg;
  localparam logic [6:0] VERSION     = 7'h25;
  localparam logic [7:0] PASSWORD    = 8'hA4;
  localparam logic [3:0] CS          = 4'b1011;
  localparam logic [1:0] ADDR_COM_LO = 2'd0;
  localparam logic [1:0] ADDR_COM_HI = 2'd1;
  localparam logic [1:0] ADDR_IND    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int         TEST_DIV    = 8;

  function automatic logic [7:0] nib_byte(input logic [3:0] n);
    return {~n, n};
  endfunction
endpackage

// File: rtl/bsk_prd_freq_div.sv
// bsk_prd_freq_div: divides clk by TEST_DIV while enabled, output held low otherwise
module bsk_prd_freq_div
  import bsk_prd_pkg::*;
(
  input  logic clk,
  input  logic iRes,
  input  logic en,
  output logic q
);
  localparam int W = $clog2(TEST_DIV) - 1;
  logic [W-1:0] cnt;
  // half-period counter; q flips each time the counter wraps
  always_ff @(posedge clk)
    if (iRes || !en) begin
      cnt <= '0;
      q   <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) q <= ~q;
    end
endmodule

// File: rtl/bsk_prd.sv
// bsk_prd: BSK bus slave with command views, indication register and test generator (option BSK_PRD_TEST_GEN_EN)
module bsk_prd
  import bsk_prd_pkg::*;
(
  input  logic        clk,
  input  logic        iRes,
  inout  wire  [15:0] bD,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [1:0]  iA,
  input  logic [3:0]  iCS,
  input  logic        iBl,
  input  logic        iDevice,
  input  logic [15:0] iCom,
  output logic [15:0] oComInd,
  output logic        oCS,
  output logic        test
);
  logic        sel, wr, test_en, unused_device;
  logic [15:0] com_ind, rd_data;
  assign unused_device = iDevice;
  assign sel     = iCS == CS;
  assign oCS     = ~sel;
  assign wr      = sel && !iWr && iRd;
  assign oComInd = ~com_ind;
  assign bD      = (sel && !iRd) ? rd_data : 16'hzzzz;
  // register read multiplexer
  always_comb
    rd_data = iA == ADDR_COM_LO ? {nib_byte(iCom[7:4]), nib_byte(iCom[3:0])} :
              iA == ADDR_COM_HI ? {nib_byte(iCom[15:12]), nib_byte(iCom[11:8])} :
              iA == ADDR_IND    ? com_ind :
                                  {PASSWORD, VERSION, test_en};
  // command indication register
  always_ff @(posedge clk)
    if (iRes) com_ind <= '0;
    else if (wr && iA == ADDR_IND) com_ind <= bD;
`ifdef BSK_PRD_TEST_GEN_EN
  // test generator enable bit
  always_ff @(posedge clk)
    if (iRes) test_en <= 1'b0;
    else if (wr && iA == ADDR_CTRL) test_en <= bD[0];
  bsk_prd_freq_div u_div (
    .clk  (clk),
    .iRes (iRes),
    .en   (test_en && iBl),
    .q    (test)
  );
`else
  logic unused_bl;
  assign unused_bl = iBl;
  assign test_en   = 1'b0;
  assign test      = 1'b0;
`endif
endmodule

// File: tb/tb_bsk_prd.sv
// tb_bsk_prd: directed self-checking bench for bsk_prd
module tb_bsk_prd;
  logic        clk = 0, iRes = 1, iRd = 1, iWr = 1, iBl = 0, iDevice = 0;
  logic [1:0]  iA = 0;
  logic [3:0]  iCS = 0;
  logic [15:0] iCom = 0, drv = 0, ind_hold;
  logic        drv_en = 0, prev;
  tri1  [15:0] bD;
  logic [15:0] oComInd;
  logic        oCS, test;
  int          tests = 0, fails = 0, tr;
`ifdef BSK_PRD_TEST_GEN_EN
  localparam logic [15:0] CTRL_ON = 16'hA44B;
  localparam int          TR_EXP  = 3;
`else
  localparam logic [15:0] CTRL_ON = 16'hA44A;
  localparam int          TR_EXP  = 0;
`endif

  assign bD = drv_en ? drv : 16'hzzzz;
  always #5 clk = ~clk;

  bsk_prd dut (
    .clk(clk), .iRes(iRes), .bD(bD), .iRd(iRd), .iWr(iWr), .iA(iA), .iCS(iCS),
    .iBl(iBl), .iDevice(iDevice), .iCom(iCom), .oComInd(oComInd), .oCS(oCS), .test(test)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [15:0] exp);
    iA = a;
    iRd = 0;
    #1 chk(tag, bD, exp);
    iRd = 1;
    #1;
  endtask

  task automatic wr(input logic [3:0] cs, input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    iCS = cs; iA = a; drv = d; drv_en = 1; iWr = 0;
    @(negedge clk);
    iWr = 1; drv_en = 0; iCS = 4'b1011;
    #1;
  endtask

  initial begin
    iCS = 4'b0000; #1 chk("cs_0000", {15'd0, oCS}, 16'd1);
    iCS = 4'b1111; #1 chk("cs_1111", {15'd0, oCS}, 16'd1);
    iCS = 4'b1011; #1 chk("cs_1011", {15'd0, oCS}, 16'd0);
    iCS = 4'b1111; #1 chk("cs_back", {15'd0, oCS}, 16'd1);
    repeat (2) @(negedge clk);
    chk("rst_ind", oComInd, 16'hFFFF);
    chk("rst_test", {15'd0, test}, 16'd0);
    iCom = 16'h1331; iCS = 4'b1011;
    rd(2'd0, "rd_in_rst", 16'hC3E1);
    iRes = 0;
    @(negedge clk);
    rd(2'd0, "rd_addr0", 16'hC3E1);
    rd(2'd1, "rd_addr1", 16'hE1C3);
    rd(2'd2, "rd_addr2", 16'h0000);
    rd(2'd3, "rd_addr3", 16'hA44A);
    #1 chk("rd_idle_z", bD, 16'hFFFF);
    iCS = 4'b1111; iRd = 0;
    #1 chk("rd_nosel_z", bD, 16'hFFFF);
    iRd = 1; iCS = 4'b1011;
    wr(4'b1011, 2'd2, 16'h9321);
    wr(4'b1011, 2'd3, 16'h9321);
    rd(2'd2, "wb_addr2", 16'h9321);
    rd(2'd3, "wb_addr3", CTRL_ON);
    chk("wb_ind", oComInd, 16'h6CDE);
    wr(4'b0011, 2'd2, 16'h0000);
    rd(2'd2, "wr_badcs", 16'h9321);
    wr(4'b1011, 2'd0, 16'h0000);
    rd(2'd0, "wr_ro_addr0", 16'hC3E1);
    @(negedge clk);
    iA = 2'd2; iRd = 0; iWr = 0;
    @(negedge clk);
    iRd = 1; iWr = 1;
    rd(2'd2, "wr_rd_low", 16'h9321);
    chk("test_bl0", {15'd0, test}, 16'd0);
    iBl = 1; tr = 0; prev = test;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (test !== prev) tr++;
      prev = test;
      if (i == 2) chk("test_edge3", {15'd0, test}, 16'd0);
      if (i == 3) chk("test_edge4", {15'd0, test}, {15'd0, TR_EXP != 0});
      if (i == 7) chk("test_edge8", {15'd0, test}, 16'd0);
    end
    chk("test_transitions", tr[15:0], TR_EXP[15:0]);
    @(negedge clk);
    iBl = 0;
    @(posedge clk); #1;
    chk("test_bl_off", {15'd0, test}, 16'd0);
    @(negedge clk);
    iBl = 1;
    repeat (3) @(posedge clk);
    #1 iRes = 1;
    @(posedge clk); #1;
    chk("test_rst", {15'd0, test}, 16'd0);
    rd(2'd2, "rst_addr2", 16'h0000);
    rd(2'd3, "rst_addr3", 16'hA44A);
    chk("rst_ind2", oComInd, 16'hFFFF);
    tr = 0; prev = test;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (test !== prev) tr++;
      prev = test;
    end
    chk("test_en0_quiet", tr[15:0], 16'd0);
    wr(4'b1011, 2'd2, 16'h9231);
    chk("ind_in_rst", oComInd, 16'hFFFF);
    iRes = 0;
    wr(4'b1011, 2'd2, 16'h9231);
    chk("ind_written", oComInd, 16'h6DCE);
    ind_hold = oComInd;
    iBl = 0; @(negedge clk);
    iCS = 4'b0000; @(negedge clk);
    iBl = 1; @(negedge clk);
    chk("ind_stable", oComInd, 16'h6DCE);
    chk("ind_vs_hold", oComInd, ind_hold);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bsk_prd.md
# bsk_prd

Bus-slave peripheral for the BSK command board: decodes a 4-bit chip select, exposes a 16-bit bidirectional data bus with four registers (two read-only views of the 16 command inputs, a command-indication register, and an ID/control register), and drives the 16 active-low indication outputs. It also generates a clk/8 test signal gated by a control bit and the block input. It sits between the host parallel bus and the command I/O connectors.

## Interface
- VERSION, 7'h25, 7-bit firmware version, readable at address 3 bits [7:1]
- PASSWORD, 8'hA4, 8-bit board signature, readable at address 3 bits [15:8]
- CS, 4'b1011, chip-select code that selects this block
- clk  input  1  system clock; all state updates on rising edge
- iRes  input  1  reset, synchronous, active-high
- bD  inout  16  host data bus, tri-state
- iRd  input  1  read strobe, active-low
- iWr  input  1  write strobe, active-low
- iA  input  2  register address
- iCS  input  4  chip-select code
- iBl  input  1  block input; 0 forces test low
- iDevice  input  1  reserved; ignored
- iCom  input  16  command inputs
- oComInd  output  16  command indication, active-low (~reg2)
- oCS  output  1  0 when iCS == CS, else 1 (combinational)
- test  output  1  test frequency output

## Operation
- sel = (iCS == CS). oCS = ~sel, independent of reset.
- Read: when sel && !iRd, bD driven combinationally from addressed register; otherwise bD = 'z. Read works during reset and while iWr is low.
- Addr 0 (RO): {~iCom[7:4], iCom[7:4], ~iCom[3:0], iCom[3:0]}.
- Addr 1 (RO): {~iCom[15:12], iCom[15:12], ~iCom[11:8], iCom[11:8]}.
- Addr 2 (RW): com_ind[15:0], reset 16'h0000. oComInd = ~com_ind.
- Addr 3: read {PASSWORD, VERSION, test_en}; write bD[0] -> test_en (reset 0); bits [15:1] ignored on write.
- Write: on rising clk when sel && !iWr && iRd && !iRes, bD latched into register iA. Writes to addresses 0/1 ignored. iRd low suppresses write (read wins).
- iBl does not affect registers or oComInd.
- Test generator: 2-bit counter plus output flop; runs when test_en && iBl; test toggles every 4 rising edges (period 8 clk, 50% duty). When disabled, counter and test cleared to 0 on next edge.

## Timing
- Reset (iRes=1 at rising edge): com_ind=0 (oComInd=16'hFFFF), test_en=0, counter=0, test=0. Reset dominates a simultaneous write.
- Write latency: register and oComInd updated on the edge where write condition is true; read-back visible immediately after.
- Holding iWr low across several edges rewrites the same value each edge; harmless.
- Enable -> first test rising edge: 4 clocks after test_en/iBl both go high. Disable: test low within 1 clock.
- Read path purely combinational: iA/iCS/iRd/iCom change -> bD same cycle.

## Configuration
- BSK_PRD_TEST_GEN_EN: defined -> test generator and test_en bit implemented as above. Undefined -> no counter; test tied 0; addr 3 bit 0 reads 0 and writes to it ignored; all other behaviour unchanged.

## Structure
- Package bsk_prd_pkg: address constants (ADDR_COM_LO=0, ADDR_COM_HI=1, ADDR_IND=2, ADDR_CTRL=3), TEST_DIV=8, helper function for nibble/complement byte encoding.
- One sub-module: bsk_prd_freq_div (enable, clk, iRes -> divided output), instantiated only under BSK_PRD_TEST_GEN_EN.

## Test plan
- Chip select: iCS=0000, 1111 -> oCS=1; iCS=1011 -> oCS=0; back to 1111 -> oCS=1.
- Read map: iCom=16'h1331, sel, iRd=0, reset released -> addr0=16'hC3E1, addr1=16'hE1C3, addr2=16'h0000, addr3=16'hA44A; iRd=1 or iCS wrong -> bD='z.
- Write/read-back: write 16'h9321 to addr2 and addr3 -> addr2 reads 16'h9321, addr3 reads 16'hA44B, oComInd=16'h6CDE; write with wrong iCS or iRd=0 -> no change; then iRes=1 one edge -> addr2=0, addr3=16'hA44A, oComInd=16'hFFFF.
- Indication: write 16'h9231 to addr2 during reset -> oComInd stays 16'hFFFF; after reset -> 16'h6DCE; toggling iBl or deselecting -> unchanged.
- Test signal: test_en=1, iBl=1 -> exactly 3 transitions in 12 clocks, period 8; iBl=0 or test_en=0 or iRes=1 -> test=0, no transitions.
